uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

UART transmitter with a small byte FIFO that carries the CNN prediction (and any follow-on bytes) off-chip on the `TX` pin. It is the transmit counterpart of the receive path that delivers the 98 image bytes via `rx_data`/`rx_rdy`. `cnn` drives it with `trmt`/`tx_data`. Bytes are queued and serialized as 8N1 frames at a fixed baud set by a clock divisor, back-to-back while the FIFO holds data.

## Interface
- `BAUD_DIV`, 434: clock cycles per bit (50 MHz / 115200); legal range 2..4095.
- `FIFO_DEPTH`, 4: byte entries; power of two, 2..16.
- `clk`  in  1  system clock; all logic on the rising edge.
- `RST_n`  in  1  reset, asynchronous and active-low.
- `trmt`  in  1  one-cycle request to queue `tx_data`.
- `tx_data`  in  8  byte to queue; sampled only when `trmt`=1.
- `TX`  out  1  serial line; idle high.
- `tx_rdy`  out  1  FIFO not full; a `trmt` in this cycle is accepted.
- `busy`  out  1  a frame is on the line, or the FIFO is non-empty.
- `tx_done`  out  1  one-cycle pulse in the last cycle of each stop bit.
- `ovf`  out  1  sticky; set when `trmt` arrives while `tx_rdy`=0.

## Operation
- **FIFO:** circular buffer with read/write pointers and a count of width clog2(`FIFO_DEPTH`)+1.
  - Push occurs when `trmt`=1 and the FIFO is not full, as evaluated at the start of the cycle.
  - Pop occurs when the FSM loads a byte.
  - Push and pop in the same cycle leave the count unchanged.
- **Full-FIFO push:** `trmt` while full drops the byte and sets `ovf`. This holds even if a pop happens in the same cycle; there is no pass-through.
- **FSM states:** IDLE, START, DATA, STOP.
  - **IDLE:** `TX`=1. If the FIFO is non-empty, pop the head into an 8-bit shift register, clear the baud counter, and go to START.
  - **START:** `TX`=0 for `BAUD_DIV` cycles, then go to DATA with `bit_cnt`=0.
  - **DATA:** `TX` = shift register bit 0, LSB first. Every `BAUD_DIV` cycles, shift right and increment `bit_cnt`. After bit 7 completes, go to STOP.
  - **STOP:** `TX`=1 for `BAUD_DIV` cycles; assert `tx_done` in the final cycle.
    - If the FIFO is non-empty in that cycle, pop and go directly to START, so there is no idle bit between frames.
    - Otherwise go to IDLE.
- **Baud counter:** counts 0..`BAUD_DIV`-1 and wraps. It is the only bit-timing source.
- **Line drive:** `TX` is driven from a flop, never combinationally from the FSM.
- **`busy`** = (state != IDLE) | FIFO non-empty.
- **Reset**, asserted asynchronously at any time including mid-frame:
  - FSM goes to IDLE and the FIFO is emptied.
  - Outputs take their reset values immediately: `TX`=1, `tx_rdy`=1, `busy`=0, `tx_done`=0, `ovf`=0.
  - The partial frame is abandoned.
- **`ovf`** is cleared only by reset.

## Timing
- **Acceptance latency:** `trmt` accepted at edge N with FSM in IDLE:
  - The FIFO becomes non-empty after edge N.
  - The FSM pops at edge N+1.
  - `TX` falls after edge N+1, i.e. the start bit begins 1 cycle after acceptance.
- **Frame length:** exactly 10×`BAUD_DIV` cycles. `tx_done` is high in cycle 10×`BAUD_DIV` of the frame, counting the first start-bit cycle as 1.
- **Back-to-back frames:** the next start bit begins in the cycle immediately after `tx_done`.
- **`tx_rdy`** is registered from the count. It deasserts in the cycle after the push that fills the FIFO, and reasserts in the cycle after a pop from full.
- **Capacity:** with `FIFO_DEPTH`=4, five `trmt` pulses on consecutive cycles starting from IDLE are all accepted. The first byte is popped at cycle +1, so at most 4 bytes are resident at once.
- **Overlapping `trmt`:** `trmt` during START/DATA/STOP only queues the byte; it never disturbs the frame in flight.

## Test plan
- **Single byte** (`BAUD_DIV`=4): reset, then `trmt` with 0x05.
  - `TX` = 0,1,0,1,0,0,0,0,0,1, each bit for 4 cycles, starting 1 cycle after acceptance.
  - `tx_done` pulses once at cycle 40; `busy` returns to 0 the cycle after.
- **Burst:** 0xA5, 0x3C, 0xFF on consecutive cycles.
  - Three frames with no idle gaps, 120 cycles total.
  - Exactly 3 `tx_done` pulses, 40 cycles apart; `ovf`=0.
- **Overflow** (`FIFO_DEPTH`=4): six consecutive `trmt` with bytes 0x01..0x06.
  - 0x01..0x05 are transmitted; 0x06 is dropped.
  - `tx_rdy`=0 during the attempted 6th push; `ovf`=1 and stays set.
- **Reset mid-frame:** drop `RST_n` during data bit 3 of 0x55.
  - `TX`=1, `busy`=0, `ovf`=0 asynchronously.
  - After release, a new `trmt` with 0x0F transmits a clean frame.
- **Push at frame end:** `trmt` with 0x80 in the same cycle as `tx_done` of the previous frame, with the FIFO otherwise empty.
  - The byte is accepted and its start bit begins 1 cycle later.
  - `TX` shows one extra idle-high cycle between the frames; the frame is correct.
- **Integration:** full `cnn` run with image 0 (label 5) and a monitor deserializing `TX` at `BAUD_DIV`.
  - Exactly one byte is received: 0x05.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter fed by a small circular byte FIFO.
// Bytes pushed with trmt are serialized LSB first at BAUD_DIV clocks per bit;
// queued bytes go out back-to-back with no idle bit between frames.
module uart_tx_fifo #(
    parameter int unsigned BAUD_DIV   = 434,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       RST_n,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       TX,
    output logic       tx_rdy,
    output logic       busy,
    output logic       tx_done,
    output logic       ovf
);

    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned BaudW = $clog2(BAUD_DIV);

    localparam logic [BaudW-1:0] BaudLast = BaudW'(BAUD_DIV - 1);
    localparam logic [CntW-1:0]  CntFull  = CntW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    // FIFO state
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    // Transmitter state
    state_e          state_q, state_d;
    logic [BaudW-1:0] baud_q, baud_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;

    // Registered outputs
    logic            tx_q, tx_d;
    logic            tx_rdy_q, tx_rdy_d;
    logic            busy_q, busy_d;
    logic            tx_done_q, tx_done_d;
    logic            ovf_q, ovf_d;

    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    logic            baud_last;
    logic [7:0]      fifo_head;

    assign fifo_full  = (count_q == CntFull);
    assign fifo_empty = (count_q == '0);
    assign baud_last  = (baud_q == BaudLast);
    assign fifo_head  = mem_q[rd_ptr_q];

    // A push into a full FIFO is dropped even if a pop happens in the same cycle.
    assign push = trmt & ~fifo_full;

    // Transmit FSM next state: bit timing comes only from the baud counter.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        pop       = 1'b0;

        unique case (state_q)
            StIdle: begin
                tx_d   = 1'b1;
                baud_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_head;
                    state_d = StStart;
                    tx_d    = 1'b0;
                end
            end
            StStart: begin
                if (baud_last) begin
                    baud_d    = '0;
                    bit_cnt_d = '0;
                    state_d   = StData;
                    tx_d      = shift_q[0];
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            StData: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = StStop;
                        tx_d    = 1'b1;
                    end else begin
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        tx_d      = shift_d[0];
                    end
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            StStop: begin
                if (baud_last) begin
                    baud_d = '0;
                    // Chain straight into the next start bit when data is waiting.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_head;
                        state_d = StStart;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = StIdle;
                        tx_d    = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
                baud_d  = '0;
            end
        endcase

        // Registered so it lines up with the final stop-bit cycle.
        tx_done_d = (state_d == StStop) && (baud_d == BaudLast);
    end

    // FIFO pointer/count update and the status flags derived from it.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase

        tx_rdy_d = (count_d != CntFull);
        busy_d   = (state_d != StIdle) || (count_d != '0);
        ovf_d    = ovf_q | (trmt & fifo_full);
    end

    // All control state and registered outputs.
    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            state_q   <= StIdle;
            baud_q    <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            tx_q      <= 1'b1;
            tx_rdy_q  <= 1'b1;
            busy_q    <= 1'b0;
            tx_done_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            tx_q      <= tx_d;
            tx_rdy_q  <= tx_rdy_d;
            busy_q    <= busy_d;
            tx_done_q <= tx_done_d;
            ovf_q     <= ovf_d;
        end
    end

    // Byte storage; contents are don't-care while the count says empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= tx_data;
        end
    end

    assign TX      = tx_q;
    assign tx_rdy  = tx_rdy_q;
    assign busy    = busy_q;
    assign tx_done = tx_done_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a queue/frame-duration reference model predicts
// acceptance, drops and start times; a monitor deserializes TX and checks
// each frame against the scoreboard.
module tb_uart_tx_fifo;

    localparam int B = 4;
    localparam int D = 4;

    logic       clk;
    logic       RST_n;
    logic       trmt;
    logic [7:0] tx_data;
    logic       TX;
    logic       tx_rdy;
    logic       busy;
    logic       tx_done;
    logic       ovf;

    uart_tx_fifo #(
        .BAUD_DIV   (B),
        .FIFO_DEPTH (D)
    ) dut (
        .clk     (clk),
        .RST_n   (RST_n),
        .trmt    (trmt),
        .tx_data (tx_data),
        .TX      (TX),
        .tx_rdy  (tx_rdy),
        .busy    (busy),
        .tx_done (tx_done),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO as a queue, a frame as 10*B cycles of line time.
    int         cyc = 0;
    int         m_left = 0;
    bit         m_ovf = 1'b0;
    logic [7:0] m_q[$];
    logic [7:0] exp_q[$];
    int         start_q[$];

    initial begin : model
        bit was_full;
        forever begin
            @(posedge clk or negedge RST_n);
            if (!RST_n) begin
                m_q.delete();
                exp_q.delete();
                start_q.delete();
                m_left = 0;
                m_ovf  = 1'b0;
            end else begin
                cyc++;
                was_full = (m_q.size() == D);
                // Line is free when idle or in the last stop-bit cycle.
                if (m_q.size() != 0 && m_left <= 1) begin
                    void'(m_q.pop_front());
                    m_left = 10 * B;
                    start_q.push_back(cyc);
                end else if (m_left > 0) begin
                    m_left--;
                end
                if (trmt === 1'b1) begin
                    if (was_full) begin
                        m_ovf = 1'b1;
                    end else begin
                        m_q.push_back(tx_data);
                        exp_q.push_back(tx_data);
                    end
                end
            end
        end
    end

    // Per-cycle status flags against the model.
    initial begin : status_chk
        forever begin
            @(negedge clk);
            if (RST_n) begin
                check("tx_rdy", int'(tx_rdy), int'(m_q.size() < D));
                check("busy", int'(busy), int'(m_left > 0 || m_q.size() > 0));
                check("ovf", int'(ovf), int'(m_ovf));
            end
        end
    end

    // Frame monitor: detects a start bit, follows the whole frame, scores it.
    initial begin : monitor
        logic [7:0] exp_b;
        logic [7:0] got_b;
        logic       exp_bit;
        int         bad_tx;
        int         bad_done;
        int         sc;
        int         bi;
        bit         aborted;
        bit         have;
        forever begin
            @(negedge clk);
            if (RST_n && TX === 1'b0) begin
                have  = (exp_q.size() > 0);
                exp_b = have ? exp_q[0] : 8'h00;
                sc    = (start_q.size() > 0) ? start_q[0] : -1;
                check("frame_start_cycle", cyc, sc);
                if (start_q.size() > 0) void'(start_q.pop_front());
                bad_tx   = 0;
                bad_done = 0;
                aborted  = 1'b0;
                got_b    = 8'h00;
                for (int k = 0; k < 10 * B; k++) begin
                    if (k > 0) @(negedge clk);
                    if (!RST_n) begin
                        aborted = 1'b1;
                        break;
                    end
                    bi = k / B;
                    if (bi == 0) exp_bit = 1'b0;
                    else if (bi == 9) exp_bit = 1'b1;
                    else exp_bit = exp_b[bi-1];
                    if (TX !== exp_bit) bad_tx++;
                    if ((k % B) == (B / 2) && bi >= 1 && bi <= 8) got_b[bi-1] = TX;
                    if (tx_done !== (k == 10 * B - 1)) bad_done++;
                end
                if (!aborted) begin
                    check("frame_expected", int'(have), 1);
                    check("frame_byte", int'(got_b), int'(exp_b));
                    check("frame_tx_bits", bad_tx, 0);
                    check("frame_tx_done", bad_done, 0);
                    if (have && exp_q.size() > 0) void'(exp_q.pop_front());
                end
            end else if (RST_n) begin
                check("idle_tx_done", int'(tx_done), 0);
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic t, input logic [7:0] d);
        @(posedge clk);
        #1;
        trmt    = t;
        tx_data = d;
    endtask

    task automatic wait_drain(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (m_left == 0 && m_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        check({name, "_drained"}, int'(done), 1);
        @(negedge clk);
        check({name, "_all_frames_seen"}, exp_q.size(), 0);
    endtask

    initial begin : stim
        bit hit;
        trmt    = 1'b0;
        tx_data = 8'h00;
        RST_n   = 1'b1;
        #2;
        RST_n = 1'b0;
        #1;
        check("rst_TX", int'(TX), 1);
        check("rst_tx_rdy", int'(tx_rdy), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_tx_done", int'(tx_done), 0);
        check("rst_ovf", int'(ovf), 0);
        repeat (2) @(posedge clk);
        #1;
        RST_n = 1'b1;

        // Single byte
        drive(1'b1, 8'h05);
        drive(1'b0, 8'h00);
        wait_drain("single");

        // Burst of three
        drive(1'b1, 8'hA5);
        drive(1'b1, 8'h3C);
        drive(1'b1, 8'hFF);
        drive(1'b0, 8'h00);
        wait_drain("burst");
        check("burst_ovf", int'(ovf), 0);

        // Overflow: sixth byte must be dropped
        for (int i = 1; i <= 6; i++) begin
            drive(1'b1, 8'(i));
            if (i == 6) check("ovf_rdy_on_6th", int'(tx_rdy), 0);
        end
        drive(1'b0, 8'h00);
        check("ovf_set", int'(ovf), 1);
        wait_drain("overflow");
        check("ovf_sticky", int'(ovf), 1);

        // Reset during data bit 3 of 0x55
        drive(1'b1, 8'h55);
        drive(1'b0, 8'h00);
        repeat (18) @(posedge clk);
        #3;
        RST_n = 1'b0;
        #1;
        check("mid_rst_TX", int'(TX), 1);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_ovf", int'(ovf), 0);
        check("mid_rst_tx_rdy", int'(tx_rdy), 1);
        repeat (2) @(posedge clk);
        #1;
        RST_n = 1'b1;
        drive(1'b1, 8'h0F);
        drive(1'b0, 8'h00);
        wait_drain("after_reset");

        // Push in the same cycle as tx_done
        drive(1'b1, 8'h3A);
        drive(1'b0, 8'h00);
        hit = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (tx_done === 1'b1) begin
                trmt    = 1'b1;
                tx_data = 8'h80;
                hit     = 1'b1;
                break;
            end
        end
        check("frame_end_push_hit", int'(hit), 1);
        drive(1'b0, 8'h00);
        wait_drain("frame_end");

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            drive(($urandom_range(0, 3) == 0), 8'($urandom));
        end
        drive(1'b0, 8'h00);
        wait_drain("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
